// File: rtl/wb_line_fetch_if.sv
// Wishbone classic read bus between the line fetcher (master) and memory (slave).
// The master holds cyc/stb and adr until the slave answers with a one-cycle ack carrying dat_i.
`timescale 1ns/1ps
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic        ack;

    modport master (output cyc, stb, we, sel, adr, input dat_i, ack);
    modport slave  (input cyc, stb, we, sel, adr, output dat_i, ack);
endinterface

// File: rtl/wb_line_fetch.sv
// Wishbone read master fetching one scanline of packed pixels per video-domain line request
// and pushing each word into the line FIFO; tracks and wraps the frame row pointer.
`timescale 1ns/1ps
module wb_line_fetch #(
    parameter int WPL   = 80,
    parameter int LINES = 480
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        line_req,
    input  logic        frame_req,
    input  logic [31:0] base_i,
    input  logic        fifo_full,
    output logic        fifo_wr,
    output logic [31:0] fifo_dat,
    output logic        busy,
    output logic        overrun,
    output logic [1:0]  state,
    if_wb.master        bus
);

    localparam int IW = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int RW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WPL - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(LINES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_PUSH = 2'd2
    } state_t;

    state_t        fsm;
    logic [IW-1:0] idx;
    logic [RW-1:0] row;
    logic [31:0]   base_q;
    logic          pend_frame;
    logic          strobe;
    logic [2:0]    line_s;
    logic [2:0]    frame_s;
    logic          line_edge;
    logic          frame_edge;

    // Bit 0 is the first synchroniser stage; edges are taken between stages two and three.
    assign line_edge  = line_s[1] & ~line_s[2];
    assign frame_edge = frame_s[1] & ~frame_s[2];

    assign bus.cyc = strobe;
    assign bus.stb = strobe;
    assign bus.we  = 1'b0;
    assign bus.sel = 4'hf;
    assign bus.adr = base_q + ((32'(row) * 32'(WPL) + 32'(idx)) << 2);

    assign fifo_wr = (fsm == S_PUSH) && !fifo_full;
    assign state   = fsm;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fsm        <= S_IDLE;
            idx        <= '0;
            row        <= '0;
            base_q     <= '0;
            pend_frame <= 1'b0;
            strobe     <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            fifo_dat   <= '0;
            line_s     <= '0;
            frame_s    <= '0;
        end else begin
            line_s  <= {line_s[1:0], line_req};
            frame_s <= {frame_s[1:0], frame_req};

            if (line_edge && fsm != S_IDLE) overrun <= 1'b1;
            if (frame_edge && fsm != S_IDLE) pend_frame <= 1'b1;

            case (fsm)
                S_IDLE: begin
                    // A frame restart seen together with a line request lands before the fetch.
                    if (frame_edge) begin
                        row    <= '0;
                        base_q <= base_i;
                    end
                    if (line_edge) begin
                        fsm    <= S_REQ;
                        strobe <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (bus.ack) begin
                        fifo_dat <= bus.dat_i;
                        strobe   <= 1'b0;
                        fsm      <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    if (!fifo_full) begin
                        if (idx != LAST_IDX) begin
                            idx    <= idx + 1'b1;
                            strobe <= 1'b1;
                            fsm    <= S_REQ;
                        end else begin
                            idx  <= '0;
                            busy <= 1'b0;
                            fsm  <= S_IDLE;
                            // A frame edge on this very cycle counts as pending too.
                            if (pend_frame || frame_edge) begin
                                row        <= '0;
                                base_q     <= base_i;
                                pend_frame <= 1'b0;
                            end else if (row == LAST_ROW) begin
                                row <= '0;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    fsm    <= S_IDLE;
                    strobe <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_line_fetch.sv
// Directed bench for wb_line_fetch: memory slave answering with adr^KEY one cycle after stb,
// FIFO write monitor, and per-line comparison against hand-derived word addresses.
`timescale 1ns/1ps
module tb_wb_line_fetch;

    localparam int          WPL   = 80;
    localparam int          LINES = 16;
    localparam logic [31:0] KEY   = 32'hA5C3_0000;

    logic        clk;
    logic        rst_i;
    logic        line_req;
    logic        frame_req;
    logic [31:0] base_i;
    logic        fifo_full;
    logic        fifo_wr;
    logic [31:0] fifo_dat;
    logic        busy;
    logic        overrun;
    logic [1:0]  state;

    if_wb bus_if ();

    wb_line_fetch #(.WPL(WPL), .LINES(LINES)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .line_req  (line_req),
        .frame_req (frame_req),
        .base_i    (base_i),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_dat  (fifo_dat),
        .busy      (busy),
        .overrun   (overrun),
        .state     (state),
        .bus       (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Memory slave: one ack per request, one cycle after stb is seen.
    always @(posedge clk) begin
        bus_if.ack   <= bus_if.cyc & bus_if.stb & ~bus_if.ack;
        bus_if.dat_i <= bus_if.adr ^ KEY;
    end

    logic [31:0] got_q[$];
    logic [31:0] adr_q[$];
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        if (fifo_wr === 1'b1) got_q.push_back(fifo_dat);
        if (bus_if.cyc === 1'b1 && bus_if.stb === 1'b1 && bus_if.ack === 1'b1)
            adr_q.push_back(bus_if.adr);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        got_q.delete();
        adr_q.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c = 0;
        while (busy === 1'b1 && c < budget) begin
            tick();
            c++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_line(input string tag, input logic [31:0] b, input int r);
        logic [31:0] obs;
        exp_q.delete();
        for (int k = 0; k < WPL; k++)
            exp_q.push_back((b + 32'((r * WPL + k) * 4)) ^ KEY);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(WPL));
        obs = (adr_q.size() > 0) ? adr_q[0] : 32'hxxxx_xxxx;
        chk({tag, "_adr_first"}, obs, b + 32'(r * WPL * 4));
        obs = (adr_q.size() == WPL) ? adr_q[WPL-1] : 32'hxxxx_xxxx;
        chk({tag, "_adr_last"}, obs, b + 32'((r * WPL + WPL - 1) * 4));
        for (int k = 0; k < WPL; k++) begin
            obs = (k < got_q.size()) ? got_q[k] : 32'hxxxx_xxxx;
            chk($sformatf("%s_w%0d", tag, k), obs, exp_q.pop_front());
        end
    endtask

    task automatic fetch_line(input string tag, input logic [31:0] b, input int r);
        clear_caps();
        line_req = 1'b1;
        repeat (4) tick();
        line_req = 1'b0;
        repeat (4) tick();
        wait_idle(tag, 2000);
        check_line(tag, b, r);
    endtask

    initial begin
        int c;
        bit found;

        rst_i     = 1'b0;
        line_req  = 1'b0;
        frame_req = 1'b0;
        base_i    = 32'h0000_1000;
        fifo_full = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_fifo_wr",  32'(fifo_wr), 32'd0);
        chk("rst_cyc",      32'(bus_if.cyc), 32'd0);
        chk("rst_stb",      32'(bus_if.stb), 32'd0);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_overrun",  32'(overrun), 32'd0);
        chk("rst_fifo_dat", fifo_dat, 32'd0);
        chk("rst_state",    32'(state), 32'd0);
        chk("rst_we",       32'(bus_if.we), 32'd0);
        chk("rst_sel",      32'(bus_if.sel), 32'hf);
        chk("rst_adr",      bus_if.adr, 32'd0);
        rst_i = 1'b1;
        repeat (2) tick();

        // T1: frame and line together, cyc on the third edge, full line at 0x1000
        clear_caps();
        frame_req = 1'b1;
        line_req  = 1'b1;
        tick();
        chk("t1_cyc_e0", 32'(bus_if.cyc), 32'd0);
        tick();
        chk("t1_cyc_e1", 32'(bus_if.cyc), 32'd0);
        tick();
        chk("t1_cyc_e2",  32'(bus_if.cyc), 32'd1);
        chk("t1_stb_e2",  32'(bus_if.stb), 32'd1);
        chk("t1_busy_e2", 32'(busy), 32'd1);
        chk("t1_adr_e2",  bus_if.adr, 32'h0000_1000);
        repeat (2) tick();
        line_req  = 1'b0;
        frame_req = 1'b0;
        repeat (4) tick();
        wait_idle("t1", 2000);
        check_line("t1", 32'h0000_1000, 0);
        chk("t1_adr_last_abs", (adr_q.size() == WPL) ? adr_q[WPL-1] : 32'hxxxx_xxxx, 32'h0000_113C);
        chk("t1_overrun", 32'(overrun), 32'd0);

        // T2: FIFO full held for 5 cycles while word 3 waits in S_PUSH
        clear_caps();
        line_req = 1'b1;
        repeat (4) tick();
        line_req = 1'b0;
        found = 1'b0;
        c = 0;
        while (!found && c < 1000) begin
            if (state == 2'd2 && adr_q.size() == 4) found = 1'b1;
            else begin
                tick();
                c++;
            end
        end
        chk("t2_reach_word3", 32'(found), 32'd1);
        fifo_full = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_wr_low_%0d", i), 32'(fifo_wr), 32'd0);
            chk($sformatf("t2_dat_hold_%0d", i), fifo_dat, (32'h0000_1000 + 32'((WPL + 3) * 4)) ^ KEY);
            tick();
        end
        chk("t2_writes_before", 32'(got_q.size()), 32'd3);
        fifo_full = 1'b0;
        wait_idle("t2", 2000);
        check_line("t2", 32'h0000_1000, 1);

        // T5: second line edge while busy is dropped and flagged
        clear_caps();
        line_req = 1'b1;
        repeat (4) tick();
        line_req = 1'b0;
        repeat (4) tick();
        chk("t5_overrun_before", 32'(overrun), 32'd0);
        line_req = 1'b1;
        repeat (4) tick();
        chk("t5_overrun_set", 32'(overrun), 32'd1);
        line_req = 1'b0;
        repeat (4) tick();
        wait_idle("t5", 2000);
        check_line("t5", 32'h0000_1000, 2);
        repeat (20) tick();
        chk("t5_no_extra_busy",   32'(busy), 32'd0);
        chk("t5_no_extra_writes", 32'(got_q.size()), 32'(WPL));
        chk("t5_overrun_sticky",  32'(overrun), 32'd1);

        for (int r = 3; r < 7; r++)
            fetch_line($sformatf("row%0d", r), 32'h0000_1000, r);

        // T4: frame request mid-line at row 7 with a new base
        clear_caps();
        line_req = 1'b1;
        repeat (4) tick();
        line_req = 1'b0;
        repeat (20) tick();
        base_i    = 32'h0000_8000;
        frame_req = 1'b1;
        repeat (4) tick();
        frame_req = 1'b0;
        wait_idle("t4a", 2000);
        check_line("t4a", 32'h0000_1000, 7);
        fetch_line("t4b", 32'h0000_8000, 0);

        // T3: run to the last row and wrap back to row 0
        for (int r = 1; r < LINES; r++)
            fetch_line($sformatf("t3_row%0d", r), 32'h0000_8000, r);
        fetch_line("t3_wrap", 32'h0000_8000, 0);
        chk("t3_overrun_sticky", 32'(overrun), 32'd1);

        // T6: reset while a request is outstanding
        clear_caps();
        line_req = 1'b1;
        c = 0;
        while (bus_if.cyc !== 1'b1 && c < 50) begin
            tick();
            c++;
        end
        chk("t6_reach_req", 32'(bus_if.cyc), 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("t6_cyc_drop",   32'(bus_if.cyc), 32'd0);
        chk("t6_stb_drop",   32'(bus_if.stb), 32'd0);
        chk("t6_wr_drop",    32'(fifo_wr), 32'd0);
        chk("t6_busy_drop",  32'(busy), 32'd0);
        chk("t6_overrun_clr", 32'(overrun), 32'd0);
        chk("t6_state_idle", 32'(state), 32'd0);
        line_req = 1'b0;
        repeat (2) tick();
        rst_i = 1'b1;
        repeat (4) tick();
        chk("t6_no_recovery_write", 32'(got_q.size()), 32'd0);
        fetch_line("t6", 32'h0000_0000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
